crack_result_collector: RTL

Downstream stage of the multicore RC4 key-search array. It consumes every core's per-core success flag, exhaustion flag and candidate key, and latches exactly one winning key. It drives the global done that halts all cores, and records the search duration in clock cycles. Its registered outputs feed the HEX and LED displays, so the top level needs no combinational key mux.

---
 rtl/crack_result_collector.sv | 149 ++++++++++++++
 1 files changed

// File: rtl/crack_result_collector.sv
// ---------------------------------------------------------------------------
// crack_result_collector
//
// Collection stage behind the multicore RC4 key-search array. It watches
// every core's success and exhaustion flags. It latches exactly one winning
// key, with the lowest core index winning any tie. It raises a global done
// that halts all cores, and it records how many search cycles elapsed before
// the decision. All outputs are registered, so the display logic can use
// them directly.
//
// Ports:
//   clk               system clock, rising edge
//   rst               synchronous active-high reset
//   real_cracked      per-core "verified key found" flags
//   failed            per-core "key slice exhausted" flags
//   final_secret_key  flattened candidate keys, core i at [i*KEY_WIDTH +: KEY_WIDTH]
//   done              high once a key is found or every core has failed
//   found             a winning key has been latched
//   exhausted         every core failed and no key was found
//   secret_key        latched winning key (0 unless found)
//   winner_core       index of the winning core (0 unless found)
//   elapsed_cycles    search cycles completed before the decision, saturating
// ---------------------------------------------------------------------------
module crack_result_collector #(
    parameter int CORE_NUMBER = 4,
    parameter int KEY_WIDTH   = 24,
    parameter int CNT_WIDTH   = 32,
    localparam int WIN_W      = (CORE_NUMBER > 1) ? $clog2(CORE_NUMBER) : 1
) (
    input  logic                            clk,
    input  logic                            rst,
    input  logic [CORE_NUMBER-1:0]          real_cracked,
    input  logic [CORE_NUMBER-1:0]          failed,
    input  logic [CORE_NUMBER*KEY_WIDTH-1:0] final_secret_key,
    output logic                            done,
    output logic                            found,
    output logic                            exhausted,
    output logic [KEY_WIDTH-1:0]            secret_key,
    output logic [WIN_W-1:0]                winner_core,
    output logic [CNT_WIDTH-1:0]            elapsed_cycles
);

    typedef enum logic [1:0] {
        SEARCH,
        FOUND,
        EXHAUSTED
    } state_e;

    state_e                 state_q, state_d;
    logic [CORE_NUMBER-1:0] fail_seen_q, fail_seen_d;
    logic                   done_q, done_d;
    logic                   found_q, found_d;
    logic                   exhausted_q, exhausted_d;
    logic [KEY_WIDTH-1:0]   key_q, key_d;
    logic [WIN_W-1:0]       win_q, win_d;
    logic [CNT_WIDTH-1:0]   elapsed_q, elapsed_d;

    // Lowest-index core with real_cracked set. Scanning from the top down
    // lets the lowest index overwrite the others.
    logic [KEY_WIDTH-1:0]   pick_key;
    logic [WIN_W-1:0]       pick_idx;
    logic [CORE_NUMBER-1:0] fail_all;

    always_comb begin
        pick_key = '0;
        pick_idx = '0;
        for (int i = CORE_NUMBER - 1; i >= 0; i--) begin
            if (real_cracked[i]) begin
                pick_key = final_secret_key[i*KEY_WIDTH +: KEY_WIDTH];
                pick_idx = WIN_W'(i);
            end
        end
    end

    // A failed pulse counts in the cycle it arrives, so the all-failed
    // decision uses the sticky history OR'd with the current flags.
    assign fail_all = fail_seen_q | failed;

    always_comb begin
        // NOTE: every next-state signal takes its hold value first, so no
        // path through the case below can leave one unassigned (no latches).
        state_d     = state_q;
        fail_seen_d = fail_seen_q;
        done_d      = done_q;
        found_d     = found_q;
        exhausted_d = exhausted_q;
        key_d       = key_q;
        win_d       = win_q;
        elapsed_d   = elapsed_q;

        case (state_q)
            SEARCH: begin
                fail_seen_d = fail_all;
                if (|real_cracked) begin
                    // A success in this cycle wins even if it also completes
                    // the all-failed condition.
                    state_d = FOUND;
                    found_d = 1'b1;
                    done_d  = 1'b1;
                    key_d   = pick_key;
                    win_d   = pick_idx;
                end else if (&fail_all) begin
                    state_d     = EXHAUSTED;
                    exhausted_d = 1'b1;
                    done_d      = 1'b1;
                end else if (elapsed_q != '1) begin
                    // The decision cycle itself is not counted, and the
                    // counter saturates instead of wrapping.
                    elapsed_d = elapsed_q + CNT_WIDTH'(1);
                end
            end
            default: begin
                // FOUND and EXHAUSTED are terminal until reset.
            end
        endcase
    end

    // NOTE: state registers use non-blocking assignments so all of them
    // update together from the values sampled at the same edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= SEARCH;
            fail_seen_q <= '0;
            done_q      <= 1'b0;
            found_q     <= 1'b0;
            exhausted_q <= 1'b0;
            key_q       <= '0;
            win_q       <= '0;
            elapsed_q   <= '0;
        end else begin
            state_q     <= state_d;
            fail_seen_q <= fail_seen_d;
            done_q      <= done_d;
            found_q     <= found_d;
            exhausted_q <= exhausted_d;
            key_q       <= key_d;
            win_q       <= win_d;
            elapsed_q   <= elapsed_d;
        end
    end

    assign done           = done_q;
    assign found          = found_q;
    assign exhausted      = exhausted_q;
    assign secret_key     = key_q;
    assign winner_core    = win_q;
    assign elapsed_cycles = elapsed_q;

endmodule
